// File: rtl/bg_pkg.sv
// bg_pkg: shared scroll types, command encodings and address field widths for the background fetcher
package bg_pkg;
  typedef enum logic [1:0] {STOPPED, RUNNING, CLEAR_PEND} scroll_state_t;
  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_START = 2'b01,
    CMD_STOP  = 2'b10,
    CMD_CLEAR = 2'b11
  } scroll_cmd_t;
  localparam int SCR_W_DEF = 640;
  localparam int SCR_H_DEF = 480;
  localparam int ADDR_X_W  = 10;
  localparam int ADDR_Y_W  = 9;
  localparam int ADDR_W    = 1 + ADDR_Y_W + ADDR_X_W;
endpackage

// File: rtl/bg_scroll_ctrl.sv
// bg_scroll_ctrl: frame tick detect, area latch and scroll FSM/offset register.
// The FSM and adder are compiled only when BG_SCROLL_EN is defined.
module bg_scroll_ctrl
  import bg_pkg::*;
#(
  parameter int BG_W_LOG2 = 10
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 VS,
  input  logic [1:0]           scroll_cmd,
  input  logic [3:0]           scroll_step,
  input  logic                 area_sel,
  output logic                 area_q,
  output logic [BG_W_LOG2-1:0] scroll_x
);
  logic vs_q;
  logic tick;
  assign tick = VS & ~vs_q;
  always_ff @(posedge Clk)
    if (!Reset_n) begin
      vs_q   <= 1'b1;
      area_q <= 1'b0;
    end else begin
      vs_q   <= VS;
      area_q <= tick ? area_sel : area_q;
    end
`ifdef BG_SCROLL_EN
  scroll_state_t        state, state_d;
  scroll_cmd_t          pend, pend_d, cmd;
  logic [BG_W_LOG2-1:0] scroll_d;
  assign cmd = scroll_cmd_t'(scroll_cmd);
  always_ff @(posedge Clk)
    if (!Reset_n) begin
      state    <= STOPPED;
      pend     <= CMD_NONE;
      scroll_x <= '0;
    end else begin
      state    <= state_d;
      pend     <= pend_d;
      scroll_x <= scroll_d;
    end
  // a command arriving on the tick cycle is kept pending for the following tick
  always_comb begin
    state_d  = state;
    scroll_d = scroll_x;
    pend_d   = (cmd == CMD_CLEAR) ? CMD_NONE : (cmd != CMD_NONE) ? cmd : tick ? CMD_NONE : pend;
    if (tick) begin
      scroll_d = (state == RUNNING) ? scroll_x + BG_W_LOG2'(scroll_step) :
                 (state == CLEAR_PEND) ? '0 : scroll_x;
      state_d  = ((state == STOPPED && pend == CMD_START) ||
                  (state == RUNNING && pend != CMD_STOP)) ? RUNNING : STOPPED;
    end
    if (cmd == CMD_CLEAR) state_d = CLEAR_PEND;
  end
`else
  logic unused_scroll;
  assign unused_scroll = ^{scroll_cmd, scroll_step};
  assign scroll_x = '0;
`endif
endmodule

// File: rtl/bg_pixel_fetch.sv
// bg_pixel_fetch: 3-stage background fetch turning DrawX/DrawY into a palette index.
// Horizontal scrolling is enabled by defining BG_SCROLL_EN; otherwise bg_x = DrawX.
module bg_pixel_fetch
  import bg_pkg::*;
#(
  parameter int BG_W_LOG2 = 10,
  parameter int SCR_W     = SCR_W_DEF,
  parameter int SCR_H     = SCR_H_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  input  logic                 VS,
  input  logic [1:0]           scroll_cmd,
  input  logic [3:0]           scroll_step,
  input  logic                 area_sel,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [3:0]           mem_data,
  output logic [3:0]           pix_index,
  output logic                 pix_valid,
  output logic                 pix_area,
  output logic [BG_W_LOG2-1:0] scroll_x
);
  logic                 area_q;
  logic [BG_W_LOG2-1:0] bg_x;
  logic                 vis, vis1, vis2, area2;
  bg_scroll_ctrl #(.BG_W_LOG2(BG_W_LOG2)) u_scroll (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .VS         (VS),
    .scroll_cmd (scroll_cmd),
    .scroll_step(scroll_step),
    .area_sel   (area_sel),
    .area_q     (area_q),
    .scroll_x   (scroll_x)
  );
  assign bg_x = BG_W_LOG2'(DrawX) + scroll_x;
  assign vis  = (32'(DrawX) < SCR_W) && (32'(DrawY) < SCR_H);
  // the area bit rides in mem_addr's top bit for its first delay stage
  always_ff @(posedge Clk)
    if (!Reset_n) begin
      mem_addr  <= '0;
      vis1      <= 1'b0;
      vis2      <= 1'b0;
      area2     <= 1'b0;
      pix_index <= '0;
      pix_valid <= 1'b0;
      pix_area  <= 1'b0;
    end else begin
      mem_addr  <= {area_q, DrawY[ADDR_Y_W-1:0], ADDR_X_W'(bg_x)};
      vis1      <= vis;
      vis2      <= vis1;
      area2     <= mem_addr[ADDR_W-1];
      pix_index <= vis2 ? mem_data : '0;
      pix_valid <= vis2;
      pix_area  <= area2;
    end
endmodule

// File: doc/bg_pixel_fetch.md
# bg_pixel_fetch

Pipelined background pixel fetcher that turns the VGA raster position into a 4-bit palette index for the current area's background. Sits between the VGA controller (DrawX/DrawY/VS) and the palette stage: it addresses the background ROM, applies per-frame horizontal scroll, and presents `pix_index` plus `pix_area`, which selects the area or forest palette downstream. All scroll and area changes take effect only on frame boundaries, so the background never tears mid-frame.

## Interface
- `BG_W_LOG2`, default 10: log2 of background width in pixels (1024). Scroll wraps modulo 2^BG_W_LOG2.
- `SCR_W`, default 640: visible width.
- `SCR_H`, default 480: visible height; background height equals SCR_H.
- `Clk` in 1: pixel clock; the only clock.
- `Reset_n` in 1: synchronous, active-low reset.
- `DrawX` in 10: current raster X, advances once per Clk.
- `DrawY` in 10: current raster Y.
- `VS` in 1: vertical sync from VGA controller, active-low. Its rising edge is the frame tick.
- `scroll_cmd` in 2: 00 none, 01 start, 10 stop, 11 clear. Sampled every cycle, latched as pending.
- `scroll_step` in 4: unsigned pixels added per frame while running.
- `area_sel` in 1: 0 area background, 1 forest background. Applied at the frame tick.
- `mem_addr` out 20: ROM address {area, DrawY[8:0], bg_x[9:0]}.
- `mem_data` in 4: ROM word, valid exactly one cycle after `mem_addr`.
- `pix_index` out 4: palette index.
- `pix_valid` out 1: 1 when `pix_index` belongs to a visible pixel.
- `pix_area` out 1: palette select aligned with `pix_index`.
- `scroll_x` out BG_W_LOG2: current committed scroll offset.

## Operation
- Frame tick: VS registered into `vs_q`. Tick = VS & ~vs_q. It lasts one cycle.
- Scroll FSM has three states:
  - STOPPED: reset state.
  - RUNNING.
  - CLEAR_PEND.
- Transitions:
  - Start moves STOPPED to RUNNING at the next tick.
  - Stop moves RUNNING to STOPPED at the next tick.
  - Clear from any state enters CLEAR_PEND. At the next tick it zeroes `scroll_x` and goes to STOPPED.
  - Pending commands are held in one register. A later command overwrites an earlier one, and clear has priority within a cycle.
- At a tick in RUNNING: `scroll_x <= scroll_x + scroll_step`, mod 2^BG_W_LOG2. Wraparound is silent, e.g. 1020 + 8 = 4.
- When the tick and a command arrive in the same cycle, the command applies at the following tick, not the current one.
- `area_q <= area_sel` at each tick.
- bg_x = DrawX + scroll_x, truncated to BG_W_LOG2 bits.
- Visible = (DrawX < SCR_W) && (DrawY < SCR_H).
- Non-visible pixels:
  - `mem_addr` still advances.
  - `pix_index` is forced to 0.
  - `pix_valid` is 0.

## Timing
- Pipeline has fixed latency 3: raster sampled at t, `mem_addr` registered at t+1, `mem_data` at t+2, `pix_index` / `pix_valid` / `pix_area` registered at t+3.
- Visible flag and area bit travel in matched delay registers.
- No stalls, and one pixel per cycle throughout.
- Reset values:
  - `mem_addr` = 0, `pix_index` = 0, `pix_valid` = 0, `pix_area` = 0, `scroll_x` = 0.
  - FSM is STOPPED, no command pending, `vs_q` = 1.
- Reset mid-frame flushes the pipeline. `pix_valid` stays 0 for 3 cycles after `Reset_n` deasserts.
- The `scroll_x` output updates the cycle after the tick. Pixels sampled at or after tick+1 use the new value.

## Configuration
- With `BG_SCROLL_EN` defined: the FSM, `scroll_cmd`, and `scroll_step` operate as above.
- Without it:
  - The FSM and adder are not compiled.
  - `scroll_x` is tied to 0, so bg_x = DrawX.
  - `scroll_cmd` and `scroll_step` are ignored.
  - Area switching on the tick and the pipeline are unchanged.

## Structure
- Package `bg_pkg` holds:
  - the scroll state enum (STOPPED, RUNNING, CLEAR_PEND);
  - the `scroll_cmd` encodings;
  - the SCR_W/SCR_H defaults;
  - the address field widths.
- Sub-module `bg_scroll_ctrl`: tick detect, FSM, and the `scroll_x` register. The top holds the address/pipeline datapath.

## Test plan
- Reset, then raster runs with ROM data = low 4 bits of address -> `pix_index` equals DrawX[3:0] 3 cycles after each sample, and `pix_valid` = 1 only for X<640, Y<480.
- start, step=8, 3 ticks -> `scroll_x` = 0, 8, 16. A pixel at DrawX=5 reads bg_x=21 after the third tick.
- `scroll_x`=1020, step=8, one tick -> `scroll_x` = 4, and DrawX=0 addresses bg_x=4.
- `area_sel` toggled mid-frame -> `pix_area` and `mem_addr[19]` change only for pixels sampled after the next tick.
- clear issued while RUNNING, with start in the same cycle -> after the next tick `scroll_x` = 0 and state is STOPPED.
- `Reset_n` asserted mid-line for 1 cycle -> all outputs 0, and `pix_valid` low for 3 cycles after release.
